// File: rtl/commit_orderer.sv
// ============================================================================
// Module   : commit_orderer
// Purpose  : In-order retirement buffer for two-slot issue bundles with
//            out-of-order completion capture.
// Config   : COMMIT_BYPASS_EN - same-cycle completion-to-retire bypass
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package commit_orderer_pkg;
    typedef struct packed {
        logic [31:0] XLEN;
    } cvw_t;
    localparam cvw_t CVW_DEFAULT = '{XLEN: 32'd32};
endpackage

module commit_orderer #(
    parameter commit_orderer_pkg::cvw_t P     = commit_orderer_pkg::CVW_DEFAULT,
    parameter int                       DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       DispValid,
    input  logic                       DispExp0,
    input  logic                       DispExp1,
    output logic                       DispReady,
    output logic [$clog2(DEPTH)-1:0]   DispTag,
    input  logic                       CmpValid,
    input  logic [$clog2(DEPTH)-1:0]   CmpTag,
    input  logic                       CmpOrder,
    input  logic [4:0]                 CmpRd,
    input  logic [P.XLEN-1:0]          CmpResult,
    output logic                       Ret0Valid,
    output logic                       Ret1Valid,
    output logic [4:0]                 Ret0Rd,
    output logic [4:0]                 Ret1Rd,
    output logic [P.XLEN-1:0]          Ret0Result,
    output logic [P.XLEN-1:0]          Ret1Result,
    output logic                       CmpErr,
    input  logic                       Flush,
    output logic [$clog2(DEPTH):0]     Occupancy
);

    localparam int          TW        = $clog2(DEPTH);
    localparam int          XLEN      = int'(P.XLEN);
    localparam logic [TW:0] c_PTR_ONE = {{TW{1'b0}}, 1'b1};

    logic [TW:0]       r_head;
    logic [TW:0]       r_tail;
    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_exp0;
    logic [DEPTH-1:0]  r_exp1;
    logic [DEPTH-1:0]  r_done0;
    logic [DEPTH-1:0]  r_done1;
    logic [DEPTH-1:0]  r_ret0;
    logic [DEPTH-1:0]  r_ret1;
    logic              r_cmperr;
    logic [4:0]        r_rd0  [DEPTH];
    logic [4:0]        r_rd1  [DEPTH];
    logic [XLEN-1:0]   r_res0 [DEPTH];
    logic [XLEN-1:0]   r_res1 [DEPTH];

    logic [TW-1:0]     w_hidx;
    logic [TW-1:0]     w_tidx;
    logic              w_full;
    logic              w_alloc;
    logic              w_cmp_exp;
    logic              w_cmp_ok;
    logic              w_byp0;
    logic              w_byp1;
    logic              w_d0;
    logic              w_d1;
    logic              w_ret0;
    logic              w_ret1;
    logic              w_free;

    assign w_hidx    = r_head[TW-1:0];
    assign w_tidx    = r_tail[TW-1:0];
    assign w_full    = (w_hidx == w_tidx) && (r_head[TW] != r_tail[TW]);

    assign DispReady = ~w_full;
    assign DispTag   = w_tidx;
    assign Occupancy = r_tail - r_head;
    assign CmpErr    = r_cmperr;

    assign w_alloc   = DispValid & ~w_full & (DispExp0 | DispExp1) & ~Flush;

    // The tail entry is never valid when an allocation can happen, so a
    // completion aimed at a just-allocated entry falls out as invalid here.
    assign w_cmp_exp = CmpOrder ? (r_exp1[CmpTag] & ~r_done1[CmpTag])
                                : (r_exp0[CmpTag] & ~r_done0[CmpTag]);
    assign w_cmp_ok  = CmpValid & ~Flush & r_valid[CmpTag] & w_cmp_exp;

`ifdef COMMIT_BYPASS_EN
    assign w_byp0 = w_cmp_ok & (CmpTag == w_hidx) & ~CmpOrder;
    assign w_byp1 = w_cmp_ok & (CmpTag == w_hidx) &  CmpOrder;
`else
    assign w_byp0 = 1'b0;
    assign w_byp1 = 1'b0;
`endif

    assign w_d0   = r_done0[w_hidx] | w_byp0;
    assign w_d1   = r_done1[w_hidx] | w_byp1;

    // Slot 1 may only leave once slot 0 is absent, already gone, or leaving now.
    assign w_ret0 = ~Flush & r_valid[w_hidx] & r_exp0[w_hidx] & w_d0 & ~r_ret0[w_hidx];
    assign w_ret1 = ~Flush & r_valid[w_hidx] & r_exp1[w_hidx] & w_d1 & ~r_ret1[w_hidx]
                  & (~r_exp0[w_hidx] | r_ret0[w_hidx] | w_ret0);
    assign w_free = ~Flush & r_valid[w_hidx]
                  & (~r_exp0[w_hidx] | r_ret0[w_hidx] | w_ret0)
                  & (~r_exp1[w_hidx] | r_ret1[w_hidx] | w_ret1);

    assign Ret0Valid  = w_ret0;
    assign Ret1Valid  = w_ret1;
    assign Ret0Rd     = w_ret0 ? (w_byp0 ? CmpRd     : r_rd0[w_hidx])  : 5'd0;
    assign Ret1Rd     = w_ret1 ? (w_byp1 ? CmpRd     : r_rd1[w_hidx])  : 5'd0;
    assign Ret0Result = w_ret0 ? (w_byp0 ? CmpResult : r_res0[w_hidx]) : '0;
    assign Ret1Result = w_ret1 ? (w_byp1 ? CmpResult : r_res1[w_hidx]) : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_valid  <= '0;
            r_exp0   <= '0;
            r_exp1   <= '0;
            r_done0  <= '0;
            r_done1  <= '0;
            r_ret0   <= '0;
            r_ret1   <= '0;
            r_cmperr <= 1'b0;
        end else if (Flush) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_valid  <= '0;
            r_cmperr <= 1'b0;
        end else begin
            r_cmperr <= CmpValid & ~w_cmp_ok;
            if (w_alloc) begin
                r_valid[w_tidx] <= 1'b1;
                r_exp0[w_tidx]  <= DispExp0;
                r_exp1[w_tidx]  <= DispExp1;
                r_done0[w_tidx] <= 1'b0;
                r_done1[w_tidx] <= 1'b0;
                r_ret0[w_tidx]  <= 1'b0;
                r_ret1[w_tidx]  <= 1'b0;
                r_tail          <= r_tail + c_PTR_ONE;
            end
            if (w_cmp_ok) begin
                if (CmpOrder) begin
                    r_done1[CmpTag] <= 1'b1;
                end else begin
                    r_done0[CmpTag] <= 1'b1;
                end
            end
            if (w_ret0) begin
                r_ret0[w_hidx] <= 1'b1;
            end
            if (w_ret1) begin
                r_ret1[w_hidx] <= 1'b1;
            end
            if (w_free) begin
                r_valid[w_hidx] <= 1'b0;
                r_head          <= r_head + c_PTR_ONE;
            end
        end
    end

    // Payload storage is only observed through a valid, done slot.
    always_ff @(posedge clk) begin
        if (w_cmp_ok) begin
            if (CmpOrder) begin
                r_rd1[CmpTag]  <= CmpRd;
                r_res1[CmpTag] <= CmpResult;
            end else begin
                r_rd0[CmpTag]  <= CmpRd;
                r_res0[CmpTag] <= CmpResult;
            end
        end
    end

endmodule

`default_nettype wire
